freq_gen: RTL
=============

# freq_gen

Programmable square-wave generator, the output-side counterpart of the team's 16-bit frequency meter. It takes a target frequency in Hz and computes the half-period in Clk cycles with an iterative divider. It then drives a 50 % duty square wave on `Fout`. Its intended uses are stimulus for the meter (loopback self-test) and a general clock/tone source; Clk is the 100 MHz system clock.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency in Hz; the divider dividend is `CLK_HZ/2`.
- `FW`, 16, frequency word width; matches the meter's 16-bit result.
- `Clk`  input  1  system clock; all state updates on rising edge.
- `Rst`  input  1  reset; asynchronous, active-high.
- `Freq`  input  FW  requested frequency in Hz; 0 means stop.
- `Load`  input  1  request strobe; sampled only when `Ready`=1.
- `Ready`  output  1  high when a new `Load` can be accepted.
- `Fout`  output  1  generated square wave, registered.
- `Active`  output  FW  frequency word currently driving `Fout`.
- `Pulse`  output  1  present only with `FREQ_GEN_PULSE_EN`; see Configuration.

## Operation
- Control FSM has three states: IDLE, DIV, COMMIT.
- **IDLE:** `Ready`=1.
  - `Load`=1 at an edge latches `Freq` into `req`, clears the iteration counter and moves to DIV.
- **DIV:** restoring divider, 32 iterations, one per cycle.
  - Computes `HP = floor((CLK_HZ/2) / req)` as a 32-bit quotient.
  - If `req`=0, HP=0; the divider is bypassed but the state still takes 32 cycles, so latency is uniform.
  - After the 32nd iteration, moves to COMMIT.
- **COMMIT:** writes `pend_hp`/`pend_freq`, sets `pend`=1, returns to IDLE.
- `Load` while `Ready`=0 is ignored and is not queued.
- A commit while `pend` is already set overwrites the pending value; last request wins.
- Generator behaviour depends on the active half-period `hp`:
  - **Stopped (`hp`=0):** `Fout`=0, `cnt`=0. If `pend`, the next edge loads `hp`/`Active` from pending and clears `pend`. `Fout` stays 0, and the first toggle comes `hp` cycles later.
  - **Running (`hp`≠0):** each edge, if `cnt`==`hp`-1 then `cnt`←0 and `Fout`←~`Fout`; otherwise `cnt`←`cnt`+1.
  - **Pending change while running:** applied only on a toggle edge. That edge loads the new `hp`/`Active` and clears `pend`, so there are no runt half-periods.
  - **Pending value is 0:** `Fout`←0 on that boundary instead of toggling, and the generator stops.
- Arithmetic:
  - `cnt` and `hp` are 32 bits.
  - Output frequency is `CLK_HZ/(2·hp)`.
  - Example: `Freq`=65535 gives `hp`=762, i.e. 65 616 Hz (truncation error accepted).
  - `Freq`=1 gives `hp`=50 000 000.

## Timing
- Reset values: `Ready`=1, `Fout`=0, `Active`=0, `Pulse`=0, `hp`=0, `cnt`=0, `pend`=0, FSM=IDLE.
- `Load` accepted at edge k:
  - `Ready` is low from after edge k.
  - Quotient is final at edge k+32.
  - `pend` and `Ready`=1 take effect at edge k+33.
- Generator stopped: `Active` updates at edge k+34, and the first `Fout` rise is at edge k+34+`hp`.
- Generator running: the change takes effect at the first toggle edge at or after k+34.
- Reset asserted mid-divide or mid-period returns immediately to reset values; any partial quotient and any pending value are discarded.
- `Load` and COMMIT cannot occur on the same edge, because `Ready`=0 in COMMIT.

## Configuration
- `FREQ_GEN_PULSE_EN` defined:
  - `Pulse` port exists.
  - `Pulse` is high for exactly one Clk cycle after each 0→1 transition of `Fout`: registered, asserted on the same edge `Fout` rises, cleared on the next edge.
- `FREQ_GEN_PULSE_EN` undefined: the `Pulse` port and its logic are absent; all other behaviour is identical.

## Test plan
- **Reset:** assert `Rst` mid-cycle with no clock edge → `Fout`=0, `Ready`=1 and `Active`=0 immediately.
- **Basic load:** `Freq`=50000, `Load` at edge k → `Ready` low for edges k+1..k+32 and high at k+33; `Active`=50000 at k+34; `Fout` rises at k+1034 and then toggles every 1000 cycles.
- **Mid-run change:** running at 50000, load 25000 → the current 1000-cycle half-period completes, then the half-period becomes 2000 with no short phase. Then load 0 → `Fout` goes low at the next boundary and stays low; `Active`=0.
- **Busy load:** `Load` with `Freq`=100 while `Ready`=0 → ignored; `Active` ends at the originally requested value.
- **Reset mid-divide:** `Rst` pulsed at k+10 → no commit occurs, `Active` stays 0, `Fout` stays 0.
- **Loopback:** `Freq`=1 with `Fout` driving the meter → meter reads 1; `Freq`=65535 gives `hp`=762.
  - With `FREQ_GEN_PULSE_EN` defined: `Pulse` is one cycle wide at each `Fout` rise.

Source files
------------

// File: rtl/freq_gen.sv
// freq_gen: programmable 50% square-wave generator with an iterative half-period divider.
// Defining FREQ_GEN_PULSE_EN adds a one-cycle Pulse output on every Fout rise.
module freq_gen #(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned FW     = 16
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic [FW-1:0] Freq,
    input  logic          Load,
    output logic          Ready,
    output logic          Fout,
`ifdef FREQ_GEN_PULSE_EN
    output logic          Pulse,
`endif
    output logic [FW-1:0] Active
);
    typedef enum logic [1:0] {IDLE, DIV, COMMIT} state_t;
    localparam logic [31:0] HALF = 32'(CLK_HZ / 2);

    state_t        state_q;
    logic [FW-1:0] req_q, rem_q, rem_d, pend_freq_q, active_q, active_d;
    logic [31:0]   quo_q, quo_d, pend_hp_q, hp_q, hp_d, cnt_q, cnt_d;
    logic [4:0]    it_q;
    logic [FW:0]   trial;
    logic          ge, pend_q, fout_q, fout_d, wrap, take;

    // quo_q starts as the dividend and shifts quotient bits in from the right
    always_comb begin
        trial    = {rem_q, quo_q[31]};
        ge       = trial >= {1'b0, req_q};
        rem_d    = ge ? FW'(trial - {1'b0, req_q}) : trial[FW-1:0];
        quo_d    = {quo_q[30:0], ge};
        wrap     = hp_q != 32'd0 && cnt_q == hp_q - 32'd1;
        take     = pend_q && (hp_q == 32'd0 || wrap);
        hp_d     = take ? pend_hp_q : hp_q;
        active_d = take ? pend_freq_q : active_q;
        cnt_d    = (hp_q == 32'd0 || wrap) ? 32'd0 : cnt_q + 32'd1;
        fout_d   = (hp_q == 32'd0 || (wrap && hp_d == 32'd0)) ? 1'b0 : wrap ? ~fout_q : fout_q;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= IDLE;
            req_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            it_q        <= '0;
            pend_q      <= 1'b0;
            pend_hp_q   <= '0;
            pend_freq_q <= '0;
            hp_q        <= '0;
            cnt_q       <= '0;
            fout_q      <= 1'b0;
            active_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (Load) begin
                    state_q <= DIV;
                    req_q   <= Freq;
                    it_q    <= '0;
                    quo_q   <= HALF;
                    rem_q   <= '0;
                end
                DIV: begin
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    it_q  <= it_q + 5'd1;
                    if (it_q == 5'd31) state_q <= COMMIT;
                end
                default: begin
                    state_q     <= IDLE;
                    pend_hp_q   <= req_q == '0 ? 32'd0 : quo_q;
                    pend_freq_q <= req_q;
                end
            endcase
            // a fresh commit wins over consumption of the older pending value
            pend_q   <= state_q == COMMIT || (pend_q && !take);
            hp_q     <= hp_d;
            cnt_q    <= cnt_d;
            fout_q   <= fout_d;
            active_q <= active_d;
        end
    end

`ifdef FREQ_GEN_PULSE_EN
    logic pulse_q;
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) pulse_q <= 1'b0;
        else     pulse_q <= fout_d & ~fout_q;
    end
    assign Pulse = pulse_q;
`endif

    assign Ready  = state_q == IDLE;
    assign Fout   = fout_q;
    assign Active = active_q;
endmodule
